// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and address validity for the register file.
package regfile_pkg;

    localparam int XLEN_DEF     = 32;
    localparam int NUM_REGS_DEF = 32;

    // An address is live if it maps to a real register and is not the hard-wired zero.
    function automatic logic addr_valid(input logic [31:0] addr, input int num_regs, input int zero_reg);
        return (addr < 32'(num_regs)) && !(zero_reg != 0 && addr == '0);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits with reserve > flush > write-clear priority.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NR_READ  = 2,
    parameter int NR_WRITE = 1,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NR_READ*AW-1:0]  rd_addr,
    output logic [NR_READ-1:0]     rd_busy,
    input  logic [NR_WRITE-1:0]    wr_en,
    input  logic [NR_WRITE*AW-1:0] wr_addr,
    input  logic                   rsv_en,
    input  logic [AW-1:0]          rsv_addr,
    input  logic                   flush
);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_nxt;

    function automatic logic wr_hit(input int r);
        logic h;
        h = 1'b0;
        for (int j = 0; j < NR_WRITE; j++)
            h = h | (wr_en[j] && wr_addr[j*AW +: AW] == AW'(r));
        return h;
    endfunction

    always_comb begin
        w_busy_nxt = r_busy;
        for (int r = 0; r < NUM_REGS; r++)
            w_busy_nxt[r] = (rsv_en && rsv_addr == AW'(r)) ? 1'b1 :
                            (flush || wr_hit(r))           ? 1'b0 : r_busy[r];
        if (ZERO_REG != 0) w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_busy <= '0;
        else        r_busy <= w_busy_nxt;
    end

    for (genvar i = 0; i < NR_READ; i++) begin : g_rd
        assign rd_busy[i] = addr_valid(32'(rd_addr[i*AW +: AW]), NUM_REGS, ZERO_REG)
                            && r_busy[rd_addr[i*AW +: AW]];
    end

endmodule

// File: rtl/regfile_multiport_sb.sv
// regfile_multiport_sb: multi-port register file with write merge, optional
// same-cycle bypass and a busy scoreboard for hazard detection.
module regfile_multiport_sb
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NR_READ  = 2,
    parameter int NR_WRITE = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NR_READ*AW-1:0]    rd_addr,
    output logic [NR_READ*XLEN-1:0]  rd_data,
    output logic [NR_READ-1:0]       rd_busy,
    input  logic [NR_WRITE-1:0]      wr_en,
    input  logic [NR_WRITE*AW-1:0]   wr_addr,
    input  logic [NR_WRITE*XLEN-1:0] wr_data,
    input  logic                     rsv_en,
    input  logic [AW-1:0]            rsv_addr,
    input  logic                     flush
);

    logic [XLEN-1:0]    r_mem [NUM_REGS];
    logic [NR_READ-1:0] w_sb_busy;

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NR_READ  (NR_READ),
        .NR_WRITE (NR_WRITE),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .rd_busy  (w_sb_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .flush    (flush)
    );

    // Ascending port order lets the highest-index writer win a same-address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) r_mem[r] <= '0;
        end else begin
            for (int j = 0; j < NR_WRITE; j++)
                if (wr_en[j] && addr_valid(32'(wr_addr[j*AW +: AW]), NUM_REGS, ZERO_REG))
                    r_mem[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
        end
    end

    for (genvar i = 0; i < NR_READ; i++) begin : g_rd
        logic [AW-1:0]   w_ra;
        logic [XLEN-1:0] w_d;
        logic            w_b;
        assign w_ra = rd_addr[i*AW +: AW];
        // Outputs are forced quiet while reset is held so bypassed inputs cannot leak.
        always_comb begin
            w_d = '0;
            w_b = 1'b0;
            if (rst_n && addr_valid(32'(w_ra), NUM_REGS, ZERO_REG)) begin
                w_d = r_mem[w_ra];
                w_b = w_sb_busy[i];
                if (BYPASS != 0)
                    for (int j = 0; j < NR_WRITE; j++)
                        if (wr_en[j] && wr_addr[j*AW +: AW] == w_ra) begin
                            w_d = wr_data[j*XLEN +: XLEN];
                            w_b = rsv_en && rsv_addr == w_ra;
                        end
            end
        end
        assign rd_data[i*XLEN +: XLEN] = w_d;
        assign rd_busy[i]              = w_b;
    end

endmodule

// File: tb/tb_regfile_multiport_sb.sv
// tb_regfile_multiport_sb: two configurations driven with identical stimulus and
// checked every cycle against an array-based reference model.
module tb_regfile_multiport_sb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  rd_addr = '0;
    logic [1:0]  wr_en = '0;
    logic [9:0]  wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic        rsv_en = 1'b0;
    logic [4:0]  rsv_addr = '0;
    logic        flush = 1'b0;
    logic [63:0] rd_data_a, rd_data_b;
    logic [1:0]  rd_busy_a, rd_busy_b;

    int checks = 0;
    int errors = 0;

    // Config A: 24 regs, zero reg, bypass. Config B: 32 regs, no zero reg, no bypass.
    int          nregs [2] = '{24, 32};
    bit          zr    [2] = '{1, 0};
    bit          byp   [2] = '{1, 0};
    logic [31:0] mem   [2][32];
    bit          busy  [2][32];

    always #5 clk = ~clk;

    regfile_multiport_sb #(.XLEN(32), .NUM_REGS(24), .NR_READ(2), .NR_WRITE(2),
                           .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush));

    regfile_multiport_sb #(.XLEN(32), .NUM_REGS(32), .NR_READ(2), .NR_WRITE(2),
                           .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush));

    function automatic bit mvalid(int d, int a);
        return a < nregs[d] && !(zr[d] && a == 0);
    endfunction

    function automatic bit wmatch(int j, int a);
        return wr_en[j] && int'(wr_addr[j*5 +: 5]) == a;
    endfunction

    function automatic logic [31:0] exp_data(int d, int a);
        logic [31:0] v;
        if (!rst_n || !mvalid(d, a)) return 32'h0;
        v = mem[d][a];
        if (byp[d])
            for (int j = 0; j < 2; j++)
                if (wmatch(j, a)) v = wr_data[j*32 +: 32];
        return v;
    endfunction

    function automatic logic exp_busy(int d, int a);
        if (!rst_n || !mvalid(d, a)) return 1'b0;
        if (byp[d] && (wmatch(0, a) || wmatch(1, a)))
            return rsv_en && int'(rsv_addr) == a;
        return busy[d][a];
    endfunction

    task automatic mreset();
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < 32; r++) begin
                mem[d][r]  = '0;
                busy[d][r] = 1'b0;
            end
    endtask

    task automatic mstep();
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < nregs[d]; r++) begin
                if (!mvalid(d, r)) continue;
                if (rsv_en && int'(rsv_addr) == r) busy[d][r] = 1'b1;
                else if (flush)                    busy[d][r] = 1'b0;
                else if (wmatch(0, r) || wmatch(1, r)) busy[d][r] = 1'b0;
            end
            for (int j = 0; j < 2; j++)
                if (wr_en[j] && mvalid(d, int'(wr_addr[j*5 +: 5])))
                    mem[d][wr_addr[j*5 +: 5]] = wr_data[j*32 +: 32];
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) mreset();
        else        mstep();
    end

    always @(negedge rst_n) mreset();

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic chkr(string n, int d, int p, logic [31:0] ed, logic eb);
        chk({n, " data"}, d == 0 ? rd_data_a[p*32 +: 32] : rd_data_b[p*32 +: 32], ed);
        chk({n, " busy"}, 32'(d == 0 ? rd_busy_a[p] : rd_busy_b[p]), 32'(eb));
    endtask

    // Continuous comparison against the model, half a cycle after inputs settle.
    always @(negedge clk) begin
        for (int p = 0; p < 2; p++) begin
            int a;
            a = int'(rd_addr[p*5 +: 5]);
            chk($sformatf("A port%0d data", p), rd_data_a[p*32 +: 32], exp_data(0, a));
            chk($sformatf("A port%0d busy", p), 32'(rd_busy_a[p]), 32'(exp_busy(0, a)));
            chk($sformatf("B port%0d data", p), rd_data_b[p*32 +: 32], exp_data(1, a));
            chk($sformatf("B port%0d busy", p), 32'(rd_busy_b[p]), 32'(exp_busy(1, a)));
        end
    end

    task automatic idle();
        wr_en  = '0;
        rsv_en = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #2;
        idle();
    endtask

    initial begin
        mreset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // zero register
        wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'hDEADBEEF};
        rsv_en = 1'b1; rsv_addr = 5'd0; rd_addr = {5'd0, 5'd0};
        #4;
        chkr("zero A same", 0, 0, 32'h0, 1'b0);
        chkr("zero B same", 1, 0, 32'h0, 1'b0);
        nxt(); #4;
        chkr("zero A next", 0, 0, 32'h0, 1'b0);
        chkr("zero B next", 1, 0, 32'hDEADBEEF, 1'b1);

        // bypass
        nxt();
        wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'h1234}; rd_addr = {5'd5, 5'd5};
        #4;
        chkr("bypass A same", 0, 0, 32'h1234, 1'b0);
        chkr("bypass B same", 1, 0, 32'h0, 1'b0);
        nxt(); #4;
        chkr("bypass A next", 0, 1, 32'h1234, 1'b0);
        chkr("bypass B next", 1, 1, 32'h1234, 1'b0);

        // write conflict: higher port wins
        nxt();
        wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'd22, 32'd11}; rd_addr = {5'd7, 5'd7};
        #4;
        chkr("conflict A same", 0, 0, 32'd22, 1'b0);
        chkr("conflict B same", 1, 0, 32'd0, 1'b0);
        nxt(); #4;
        chkr("conflict A next", 0, 0, 32'd22, 1'b0);
        chkr("conflict B next", 1, 1, 32'd22, 1'b0);

        // scoreboard
        nxt();
        rsv_en = 1'b1; rsv_addr = 5'd3; rd_addr = {5'd3, 5'd3};
        #4;
        chkr("rsv A same", 0, 0, 32'h0, 1'b0);
        nxt(); #4;
        chkr("rsv A next", 0, 0, 32'h0, 1'b1);
        chkr("rsv B next", 1, 0, 32'h0, 1'b1);
        nxt();
        wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'd99};
        #4;
        chkr("clr A same", 0, 0, 32'd99, 1'b0);
        chkr("clr B same", 1, 0, 32'd0, 1'b1);
        nxt(); #4;
        chkr("clr A next", 0, 0, 32'd99, 1'b0);
        chkr("clr B next", 1, 0, 32'd99, 1'b0);
        nxt();
        rsv_en = 1'b1; rsv_addr = 5'd3;
        wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'd77};
        #4;
        chkr("rsvwr A same", 0, 0, 32'd77, 1'b1);
        chkr("rsvwr B same", 1, 0, 32'd99, 1'b0);
        nxt(); #4;
        chkr("rsvwr A next", 0, 0, 32'd77, 1'b1);
        chkr("rsvwr B next", 1, 0, 32'd77, 1'b1);
        nxt();
        rsv_en = 1'b1; rsv_addr = 5'd4; flush = 1'b1; rd_addr = {5'd4, 5'd3};
        #4;
        chkr("flush A same", 0, 0, 32'd77, 1'b1);
        nxt(); #4;
        chkr("flush A x3", 0, 0, 32'd77, 1'b0);
        chkr("flush A x4", 0, 1, 32'd0, 1'b1);
        chkr("flush B x4", 1, 1, 32'd0, 1'b1);

        // out of range for A (24 regs), in range for B
        nxt();
        wr_en = 2'b01; wr_addr = {5'd0, 5'd30}; wr_data = {32'h0, 32'd5}; rd_addr = {5'd6, 5'd30};
        #4;
        chkr("range A same", 0, 0, 32'd0, 1'b0);
        chkr("range B same", 1, 0, 32'd0, 1'b0);
        nxt(); #4;
        chkr("range A x30", 0, 0, 32'd0, 1'b0);
        chkr("range A x6", 0, 1, 32'd0, 1'b0);
        chkr("range B x30", 1, 0, 32'd5, 1'b0);

        // mid-cycle reset after filling every register
        nxt();
        for (int a = 0; a < 32; a++) begin
            wr_en = 2'b01; wr_addr = {5'd0, 5'(a)}; wr_data = {32'h0, 32'(a) + 32'h100};
            @(posedge clk); #2;
        end
        idle();
        rd_addr = {5'd7, 5'd5};
        wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hCAFE};
        rsv_en = 1'b1; rsv_addr = 5'd5;
        #1 rst_n = 1'b0;
        #1;
        for (int p = 0; p < 2; p++) begin
            chkr("reset A", 0, p, 32'h0, 1'b0);
            chkr("reset B", 1, p, 32'h0, 1'b0);
        end
        #4 idle();
        rst_n = 1'b1;
        nxt(); #4;
        for (int p = 0; p < 2; p++) begin
            chkr("post reset A", 0, p, 32'h0, 1'b0);
            chkr("post reset B", 1, p, 32'h0, 1'b0);
        end

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            nxt();
            rst_n    = 1'b1;
            wr_en    = 2'($urandom);
            wr_addr  = 10'($urandom);
            wr_data  = {$urandom, $urandom};
            rd_addr  = 10'($urandom);
            if ($urandom_range(0, 1) == 0) rd_addr[4:0] = wr_addr[4:0];
            if ($urandom_range(0, 1) == 0) rd_addr[9:5] = wr_addr[9:5];
            rsv_en   = ($urandom_range(0, 3) == 0);
            rsv_addr = $urandom_range(0, 1) == 0 ? rd_addr[4:0] : 5'($urandom);
            flush    = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
        end
        nxt();
        rst_n = 1'b1;
        repeat (2) nxt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
